// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one main-memory port between two requesters
// Ports: clk, rst_n (async, active-low);
//        p0_*/p1_*: rd_req, wr_req, addr, wdata in; rdata, ready, err out (requester side);
//        mem_*: addr, data_out, read_req, write_req out; data_in, ready in (memory side);
//        busy, grant_id: status of the current or last transaction.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int LINE_W         = 512,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_rd_req,
    input  logic              p0_wr_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p0_wdata,
    output logic [LINE_W-1:0] p0_rdata,
    output logic              p0_ready,
    output logic              p0_err,
    input  logic              p1_rd_req,
    input  logic              p1_wr_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [ADDR_W-1:0] p1_wdata,
    output logic [LINE_W-1:0] p1_rdata,
    output logic              p1_ready,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_data_out,
    output logic              mem_read_req,
    output logic              mem_write_req,
    input  logic [LINE_W-1:0] mem_data_in,
    input  logic              mem_ready,
    output logic              busy,
    output logic              grant_id
);
    localparam int WD_W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, state_d;
    logic last, last_d, grant_d, win, rd_d, wr_d;
    logic [WD_W-1:0] wd, wd_d;
    logic [ADDR_W-1:0] addr_d, wdata_d;
    logic [LINE_W-1:0] rdata0_d, rdata1_d;
    logic [1:0] ready_d, err_d;
    logic req0, req1;
    assign req0 = p0_rd_req | p0_wr_req;
    assign req1 = p1_rd_req | p1_wr_req;
    always_comb begin
        state_d  = state;
        last_d   = last;
        grant_d  = grant_id;
        wd_d     = wd;
        addr_d   = mem_addr;
        wdata_d  = mem_data_out;
        rd_d     = mem_read_req;
        wr_d     = mem_write_req;
        rdata0_d = p0_rdata;
        rdata1_d = p1_rdata;
        ready_d  = 2'b00;
        err_d    = 2'b00;
        win      = 1'b0;
        case (state)
            IDLE: if (req0 | req1) begin
                // a lone requester wins; a tie goes to the port not served last
                win     = req1 & (~req0 | ~last);
                last_d  = win;
                grant_d = win;
                addr_d  = win ? p1_addr : p0_addr;
                wdata_d = win ? p1_wdata : p0_wdata;
                wr_d    = win ? p1_wr_req : p0_wr_req;
                rd_d    = win ? (p1_rd_req & ~p1_wr_req) : (p0_rd_req & ~p0_wr_req);
                wd_d    = '0;
                state_d = ISSUE;
            end
            ISSUE: begin
                // completion takes precedence over a watchdog expiry on the same edge
                if (mem_ready || wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rd_d              = 1'b0;
                    wr_d              = 1'b0;
                    ready_d[grant_id] = 1'b1;
                    err_d[grant_id]   = ~mem_ready;
                    rdata0_d          = (mem_ready && mem_read_req && !grant_id) ? mem_data_in : p0_rdata;
                    rdata1_d          = (mem_ready && mem_read_req && grant_id) ? mem_data_in : p1_rdata;
                    state_d           = RESP;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last          <= 1'b1;
            grant_id      <= 1'b0;
            wd            <= '0;
            mem_addr      <= '0;
            mem_data_out  <= '0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            p0_rdata      <= '0;
            p1_rdata      <= '0;
            p0_ready      <= 1'b0;
            p1_ready      <= 1'b0;
            p0_err        <= 1'b0;
            p1_err        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            last          <= last_d;
            grant_id      <= grant_d;
            wd            <= wd_d;
            mem_addr      <= addr_d;
            mem_data_out  <= wdata_d;
            mem_read_req  <= rd_d;
            mem_write_req <= wr_d;
            p0_rdata      <= rdata0_d;
            p1_rdata      <= rdata1_d;
            p0_ready      <= ready_d[0];
            p1_ready      <= ready_d[1];
            p0_err        <= err_d[0];
            p1_err        <= err_d[1];
            busy          <= state_d != IDLE;
        end
    end
endmodule
